// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and its line-level constants.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Parity polarity: 0 gives even parity (parity bit = XOR of data bits).
    localparam logic PARITY_POL = 1'b0;

endpackage

// File: rtl/serial_frame_tx_piso_shift.sv
// Parallel-in serial-out shifter: holds the frame word, presents the current bit on
// sout and the frame parity on parity_out. Shifts right (LSB first), filling with zero.
module piso_shift
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    output logic              sout,
    output logic              parity_out
);

    logic [DATA_W-1:0] shreg;
    logic              par_q;

    // Capture word and its parity on load, otherwise shift toward the LSB when asked.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg <= '0;
            par_q <= 1'b0;
        end else if (load) begin
            shreg <= data_in;
            par_q <= (^data_in) ^ PARITY_POL;
        end else if (shift) begin
            shreg <= {1'b0, shreg[DATA_W-1:1]};
        end
    end

    assign sout       = shreg[0];
    assign parity_out = par_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even parity,
// stop bit. Bit advance is gated by the en strobe; load capture is not.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line idle (1), ready for load
// ST_START  | start bit (0) on the line
// ST_DATA   | data bit bit_cnt on the line
// ST_PARITY | even parity bit on the line
// ST_STOP   | stop bit (1) on the line; en returns to idle
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              dout
);

    localparam int             CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_W - 1);

    tx_state_t     state, state_nx;
    logic [CW-1:0] bit_cnt;
    logic          last_bit;
    logic          load_acc;
    logic          shift_en;
    logic          dout_nx;
    logic          sout;
    logic          par_bit;

    assign last_bit = (bit_cnt == LAST_BIT);

    // The shifter is advanced once when leaving START and once per data bit, so its
    // LSB is always the bit that goes on the line at the next en edge.
    piso_shift #(.DATA_W(DATA_W)) u_piso (
        .CLK        (CLK),
        .RST        (RST),
        .load       (load_acc),
        .shift      (shift_en),
        .data_in    (data_in),
        .sout       (sout),
        .parity_out (par_bit)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: load leaves IDLE without en, every other move needs en.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (load) state_nx = ST_START;
            ST_START:  if (en)   state_nx = ST_DATA;
            ST_DATA:   if (en && last_bit) state_nx = PARITY_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (en)   state_nx = ST_STOP;
            ST_STOP:   if (en)   state_nx = ST_IDLE;
            default:             state_nx = ST_IDLE;
        endcase
    end

    // Output decode: handshake flags, shifter control and the next line level.
    always_comb begin
        ready    = (state == ST_IDLE);
        busy     = ~ready;
        load_acc = ready & load;
        shift_en = 1'b0;
        dout_nx  = dout;
        case (state)
            ST_IDLE:   dout_nx = load ? START_BIT : LINE_IDLE;
            ST_START: begin
                if (en) begin
                    shift_en = 1'b1;
                    dout_nx  = sout;
                end
            end
            ST_DATA: begin
                if (en) begin
                    if (last_bit) begin
                        dout_nx = PARITY_EN ? par_bit : STOP_BIT;
                    end else begin
                        shift_en = 1'b1;
                        dout_nx  = sout;
                    end
                end
            end
            ST_PARITY: if (en) dout_nx = STOP_BIT;
            ST_STOP:   if (en) dout_nx = LINE_IDLE;
            default:           dout_nx = LINE_IDLE;
        endcase
    end

    // Registered line output and end-of-frame pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout <= LINE_IDLE;
            done <= 1'b0;
        end else begin
            dout <= dout_nx;
            done <= (state == ST_STOP) && en;
        end
    end

    // Data bit index: cleared entering DATA, saturates at the last bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (state == ST_START && en) begin
            bit_cnt <= '0;
        end else if (state == ST_DATA && en && !last_bit) begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

endmodule
